uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver, 8N1, LSB first. Converts the asynchronous rx_pin line into bytes. Each received byte is presented on a single-entry valid/ready output register to the CPU/peripheral bus side. It is the receive counterpart of uart_tx and shares its baud arithmetic.

Parameters:
UART_CLK_HZ, 50000000, clk frequency in Hz
BAUD_RATE, 115200, serial bit rate
Derived: CYCLE = UART_CLK_HZ / BAUD_RATE, 16-bit, integer division. HALF = CYCLE / 2. CYCLE >= 4 is required.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous assert, active-low
rx_pin  input  1  serial data in; asynchronous to clk; idle high
rx_data  output  8  received byte; stable while rx_data_valid = 1
rx_data_valid  output  1  byte available
rx_data_ready  input  1  consumer accepts; transfer occurs when valid & ready on a clk edge
frame_err  output  1  1-cycle pulse: stop bit sampled low
overrun  output  1  1-cycle pulse: completed byte dropped because holding register full

Behaviour:
- Synchronizer: rx_pin passes through 2 flops (rx_s1, rx_s2), both reset to 1. A third flop, rx_prev, also resets to 1. A falling edge is rx_prev = 1 & rx_s2 = 0. All FSM logic uses rx_s2 only.
- Reset values: rx_data = 0, rx_data_valid = 0, frame_err = 0, overrun = 0, state = IDLE, cycle_cnt = 0, bit_cnt = 0.
- cycle_cnt is 16-bit. It is cleared on every state change and at each DATA sample; otherwise it increments.
- FSM states:
  - IDLE: on falling edge -> START.
  - START: at cycle_cnt == HALF-1, sample rx_s2. If 0 -> DATA. If 1 -> IDLE (glitch rejected, no flags raised).
  - DATA: at cycle_cnt == CYCLE-1, shift rx_s2 into shift_reg[bit_cnt] (LSB first) and increment bit_cnt. Sampling after bit 7 (bit_cnt == 7) -> STOP.
  - STOP: at cycle_cnt == CYCLE-1, sample the stop bit and go to IDLE. Returning at mid-stop allows back-to-back frames.
- Stop bit = 1, byte completes:
  - If rx_data_valid = 0, or valid & ready in the same cycle: load rx_data with shift_reg on the next edge, rx_data_valid = 1.
  - Otherwise: keep the old rx_data, drop the new byte, pulse overrun for 1 cycle.
- Stop bit = 0: pulse frame_err for 1 cycle, discard the byte, leave rx_data / rx_data_valid unchanged.
- Break or stuck-low line: after a framing error, no new frame starts until rx_s2 returns high and then falls again. The edge detector enforces this.
- rx_data_valid clears on valid & ready unless a new byte loads in that same cycle. Simultaneous load and accept leaves valid = 1 with the new data, and no overrun.
- rx_data_ready while valid = 0 has no effect. rx_data never changes while valid = 1 and not accepted.
- Latency: edge at pin -> START entry is 3 clk (2 sync + edge reg). With CYCLE = 10, rx_data_valid rises 3 + 5 + 8*10 + 10 + 1 = 99 clk after the pin falls (±1 clk of sync phase).
- Reset asserted mid-frame: all state returns to reset values immediately; the partial byte is lost and no flags are raised. After release, a line that is already low is not taken as a start bit; a new high->low transition is required.

Test Plan:
- CYCLE = 10 (UART_CLK_HZ = 1000000, BAUD_RATE = 100000), ready held 1. Send 0xA5 -> rx_data = 0xA5, valid high exactly 1 cycle, ~99 clk after the start edge; frame_err = overrun = 0.
- Back-to-back 0x00, 0xFF, 0x3C with 1-bit stop spacing, ready = 1 -> three valid pulses carrying 0x00, 0xFF, 0x3C in order.
- Ready held 0. Send 0x11 then 0x22 -> valid stays 1 with rx_data = 0x11, overrun pulses once at the 0x22 stop sample. Then raise ready -> valid falls next cycle.
- Send 0x55 with the stop bit forced low -> frame_err 1-cycle pulse, valid stays 0. Line then held low 30 clk, then high, then a normal frame 0x5A -> only 0x5A is received.
- 3-clk low glitch on idle line -> no valid, no frame_err, FSM back in IDLE. Also assert rst_n mid-data-bit of 0x81 -> outputs return to reset values, and the next clean frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a single-entry valid/ready holding register.
// Baud timing is derived from UART_CLK_HZ / BAUD_RATE, the same arithmetic as uart_tx.
module uart_rx #(
  parameter int UART_CLK_HZ = 50000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] CYCLE = 16'(UART_CLK_HZ / BAUD_RATE);
  localparam logic [15:0] HALF  = CYCLE >> 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic        rx_s1, rx_s2, rx_prev;
  logic [1:0]  fill;
  logic        armed;
  logic        fall;
  logic [1:0]  state;
  logic [15:0] cycle_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        byte_done;
  logic        stop_ok;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_pin;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // The synchronizer resets high, so a line already low at reset release would
  // look like a falling edge. Starts are only armed once the real line is seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && rx_s2) armed <= 1'b1;
    end
  end

  assign fall = armed & rx_prev & ~rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cycle_cnt <= 16'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      byte_done <= 1'b0;
      stop_ok   <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          cycle_cnt <= 16'd0;
          bit_cnt   <= 3'd0;
          if (fall) state <= START;
        end
        START: begin
          if (cycle_cnt == HALF - 16'd1) begin
            cycle_cnt <= 16'd0;
            state     <= rx_s2 ? IDLE : DATA;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        DATA: begin
          if (cycle_cnt == CYCLE - 16'd1) begin
            cycle_cnt          <= 16'd0;
            shift_reg[bit_cnt] <= rx_s2;
            bit_cnt            <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        default: begin
          // Leaving at mid-stop lets an immediately following start bit be caught.
          if (cycle_cnt == CYCLE - 16'd1) begin
            cycle_cnt <= 16'd0;
            state     <= IDLE;
            byte_done <= 1'b1;
            stop_ok   <= rx_s2;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign accept = rx_data_valid & rx_data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= 8'd0;
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= byte_done & ~stop_ok;
      overrun   <= 1'b0;
      if (byte_done && stop_ok && (!rx_data_valid || accept)) begin
        rx_data       <= shift_reg;
        rx_data_valid <= 1'b1;
      end else begin
        if (byte_done && stop_ok) overrun <= 1'b1;
        if (accept) rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at CYCLE = 10: stimulus pushes expected
// bytes/flags from a frame-level model, a negedge monitor pops and compares.
module tb_uart_rx;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CYC    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.UART_CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int         lat_q[$];
  int exp_ferr = 0, exp_ovr = 0, got_ferr = 0, got_ovr = 0;
  bit model_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame-level model: a good frame is delivered if the holder is free or the
  // consumer is ready, otherwise it is an overrun; a low stop bit is a frame error.
  task automatic send_frame(input logic [7:0] d, input bit stop);
    if (!stop) exp_ferr++;
    else if (rx_data_ready || !model_full) begin
      exp_q.push_back(d);
      lat_q.push_back(rx_data_ready ? cyc : -1);
      model_full = !rx_data_ready;
    end else exp_ovr++;
    rx_pin = 1'b0;
    tick(CYC);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      tick(CYC);
    end
    rx_pin = stop;
    tick(CYC);
    if (stop) rx_pin = 1'b1;
  endtask

  bit prev_hold = 0, prev_ferr = 0, prev_ovr = 0;
  logic [7:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
      prev_ferr = 0;
      prev_ovr  = 0;
    end else begin
      if (prev_hold && rx_data_valid) check("hold_stable", rx_data, held);
      if (rx_data_valid && rx_data_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          int st;
          check("rx_data", rx_data, exp_q.pop_front());
          st = lat_q.pop_front();
          if (st >= 0) begin
            tests++;
            if (cyc - st < 98 || cyc - st > 100) begin
              fails++;
              $display("FAIL latency: got %0d expected 98..100", cyc - st);
            end
          end
        end
      end
      if (frame_err) begin
        got_ferr++;
        check("frame_err_width", prev_ferr, 0);
      end
      if (overrun) begin
        got_ovr++;
        check("overrun_width", prev_ovr, 0);
      end
      prev_hold = rx_data_valid && !rx_data_ready;
      held      = rx_data;
      prev_ferr = frame_err;
      prev_ovr  = overrun;
    end
  end

  initial begin
    int waited;
    #1;
    tick(3);
    check("rst_valid", rx_data_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    tick(5);

    send_frame(8'hA5, 1'b1);
    tick(20);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(20);

    for (int n = 0; n < 8; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      tick($urandom_range(0, 25));
    end
    tick(20);

    rx_data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(20);
    check("held_valid", rx_data_valid, 1);
    check("held_data", rx_data, 8'h11);
    rx_data_ready = 1'b1;
    model_full = 1'b0;
    tick(1);
    check("valid_falls", rx_data_valid, 0);
    tick(10);

    send_frame(8'h55, 1'b0);
    tick(30);
    check("break_no_valid", rx_data_valid, 0);
    rx_pin = 1'b1;
    tick(20);
    send_frame(8'h5A, 1'b1);
    tick(20);

    rx_pin = 1'b0;
    tick(3);
    rx_pin = 1'b1;
    tick(30);
    check("glitch_no_valid", rx_data_valid, 0);
    send_frame(8'h3C, 1'b1);
    tick(20);

    rx_pin = 1'b0;
    tick(CYC);
    rx_pin = 1'b1;
    tick(CYC);
    rx_pin = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    check("midrst_valid", rx_data_valid, 0);
    check("midrst_data", rx_data, 0);
    rst_n = 1'b1;
    tick(20);
    rx_pin = 1'b1;
    tick(20);
    check("postrst_no_valid", rx_data_valid, 0);
    send_frame(8'h42, 1'b1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      tick(1);
      waited++;
    end
    check("queue_drained", exp_q.size(), 0);
    tick(5);
    check("frame_err_count", got_ferr, exp_ferr);
    check("overrun_count", got_ovr, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
